// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared types and constants for the APU dispatch scoreboard.
package cv32e40p_apu_core_pkg;

  // Default register-file write address width for tag entries
  localparam int unsigned APU_WADDR_W = 6;

  // Latency classes reported by the APU for each operation
  localparam logic [1:0] APU_LAT_SINGLE = 2'd0;
  localparam logic [1:0] APU_LAT_TWO    = 2'd1;
  localparam logic [1:0] APU_LAT_MULTI  = 2'd2;

  // One outstanding operation: where its result goes and how long it takes
  typedef struct packed {
    logic [APU_WADDR_W-1:0] waddr;
    logic [1:0]             lat;
  } apu_tag_t;

  // Classes 2 and 3 both count as multicycle
  function automatic logic apu_lat_is_multi(input logic [1:0] lat);
    return (lat >= APU_LAT_MULTI);
  endfunction

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// In-order tag queue for outstanding APU operations. Exposes every slot and
// its occupancy so the parent can compare against all in-flight destinations.
module cv32e40p_apu_tag_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  apu_tag_t              push_data_i,
  input  logic                  pop_i,
  output apu_tag_t              head_o,
  output apu_tag_t [DEPTH-1:0]  entries_o,
  output logic     [DEPTH-1:0]  occupied_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  apu_tag_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);

  // A push into a full queue is dropped; a pop of an empty queue is ignored
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;

  // Slot gi is live when its distance from the read pointer is below the count
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    assign occupied_o[gi] = ((gi >= int'(rd_ptr_q)) ? (gi - int'(rd_ptr_q))
                                                    : (gi + int'(DEPTH) - int'(rd_ptr_q)))
                            < int'(count_q);
  end

  // Next-state pointers wrap modulo DEPTH; simultaneous push/pop holds count
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy state; reset discards every outstanding entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, cleared so the head outputs are defined while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/cv32e40p_apu_scoreboard.sv
// Dispatch controller between EX and the shared APU: issues requests,
// tracks in-flight destinations, returns result tags and flags hazards.
module cv32e40p_apu_scoreboard
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned WADDR_W = APU_WADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic [1:0]             apu_lat_i,
  input  logic [WADDR_W-1:0]     apu_waddr_i,
  input  logic                   is_decoding_i,
  input  logic [3*WADDR_W-1:0]   read_regs_i,
  input  logic [2:0]             read_regs_valid_i,
  input  logic [2*WADDR_W-1:0]   write_regs_i,
  input  logic [1:0]             write_regs_valid_i,
  output logic                   apu_req_o,
  input  logic                   apu_gnt_i,
  input  logic                   apu_rvalid_i,
  output logic                   apu_valid_o,
  output logic [WADDR_W-1:0]     apu_waddr_o,
  output logic                   apu_singlecycle_o,
  output logic                   apu_multicycle_o,
  output logic                   apu_active_o,
  output logic                   apu_stall_o,
  output logic                   read_dep_o,
  output logic                   write_dep_o,
  output logic                   perf_type_o,
  output logic                   perf_cont_o
);

  apu_tag_t             push_data;
  apu_tag_t             head;
  apu_tag_t [DEPTH-1:0] entries;
  logic     [DEPTH-1:0] occupied;
  logic                 empty, full;
  logic                 push, pop;
  logic                 raw_hit, waw_hit;

  assign push_data.waddr = APU_WADDR_W'(apu_waddr_i);
  assign push_data.lat   = apu_lat_i;

  cv32e40p_apu_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .entries_o   (entries),
    .occupied_o  (occupied),
    .empty_o     (empty),
    .full_o      (full)
  );

  // Compare every valid ID register against every live slot. A slot being
  // popped this cycle is still live, which keeps the check conservative.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int e = 0; e < int'(DEPTH); e++) begin
      for (int r = 0; r < 3; r++) begin
        if (occupied[e] && read_regs_valid_i[r] &&
            (read_regs_i[r*WADDR_W +: WADDR_W] == WADDR_W'(entries[e].waddr))) begin
          raw_hit = 1'b1;
        end
      end
      for (int w = 0; w < 2; w++) begin
        if (occupied[e] && write_regs_valid_i[w] &&
            (write_regs_i[w*WADDR_W +: WADDR_W] == WADDR_W'(entries[e].waddr))) begin
          waw_hit = 1'b1;
        end
      end
    end
  end

  assign read_dep_o  = is_decoding_i & raw_hit;
  assign write_dep_o = is_decoding_i & waw_hit;

  // Request depends only on registered occupancy and hazards, never on the
  // grant, so it stays stable until accepted
  assign apu_req_o   = enable_i & ~full & ~read_dep_o & ~write_dep_o;
  assign push        = apu_req_o & apu_gnt_i;
  assign pop         = apu_rvalid_i & ~empty;

  assign apu_stall_o = enable_i & ~push;
  assign perf_type_o = enable_i & (read_dep_o | write_dep_o);
  assign perf_cont_o = apu_stall_o & ~perf_type_o;

  // Result tag comes straight from the head entry, zero latency from rvalid
  assign apu_valid_o       = pop;
  assign apu_waddr_o       = WADDR_W'(head.waddr);
  assign apu_singlecycle_o = (head.lat == APU_LAT_SINGLE);
  assign apu_multicycle_o  = apu_lat_is_multi(head.lat);
  assign apu_active_o      = ~empty;

endmodule

// File: tb/tb_cv32e40p_apu_scoreboard.sv
// Directed self-checking bench for the APU dispatch scoreboard (DEPTH=2).
module tb_cv32e40p_apu_scoreboard;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable_i = 1'b0;
  logic [1:0]     apu_lat_i = '0;
  logic [W-1:0]   apu_waddr_i = '0;
  logic           is_decoding_i = 1'b0;
  logic [3*W-1:0] read_regs_i = '0;
  logic [2:0]     read_regs_valid_i = '0;
  logic [2*W-1:0] write_regs_i = '0;
  logic [1:0]     write_regs_valid_i = '0;
  logic           apu_gnt_i = 1'b0;
  logic           apu_rvalid_i = 1'b0;
  logic           apu_req_o, apu_valid_o, apu_singlecycle_o, apu_multicycle_o;
  logic           apu_active_o, apu_stall_o, read_dep_o, write_dep_o;
  logic           perf_type_o, perf_cont_o;
  logic [W-1:0]   apu_waddr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_scoreboard #(.DEPTH(2), .WADDR_W(W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable_i           (enable_i),
    .apu_lat_i          (apu_lat_i),
    .apu_waddr_i        (apu_waddr_i),
    .is_decoding_i      (is_decoding_i),
    .read_regs_i        (read_regs_i),
    .read_regs_valid_i  (read_regs_valid_i),
    .write_regs_i       (write_regs_i),
    .write_regs_valid_i (write_regs_valid_i),
    .apu_req_o          (apu_req_o),
    .apu_gnt_i          (apu_gnt_i),
    .apu_rvalid_i       (apu_rvalid_i),
    .apu_valid_o        (apu_valid_o),
    .apu_waddr_o        (apu_waddr_o),
    .apu_singlecycle_o  (apu_singlecycle_o),
    .apu_multicycle_o   (apu_multicycle_o),
    .apu_active_o       (apu_active_o),
    .apu_stall_o        (apu_stall_o),
    .read_dep_o         (read_dep_o),
    .write_dep_o        (write_dep_o),
    .perf_type_o        (perf_type_o),
    .perf_cont_o        (perf_cont_o)
  );

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled well away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    enable_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; is_decoding_i = 0;
    read_regs_valid_i = '0; write_regs_valid_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
    #1;
    $display("test_reset: idle after reset");
    checks++; if (apu_active_o !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", apu_active_o); end
    checks++; if ({apu_req_o, apu_valid_o, apu_stall_o, perf_type_o, perf_cont_o} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {apu_req_o, apu_valid_o, apu_stall_o, perf_type_o, perf_cont_o}); end
    checks++; if ({read_dep_o, write_dep_o, apu_singlecycle_o, apu_multicycle_o} !== 4'b0010 &&
                  {read_dep_o, write_dep_o, apu_multicycle_o} !== 3'b000) begin errors++;
      $display("FAIL reset_deps: got rd=%b wd=%b multi=%b expected 0", read_dep_o, write_dep_o, apu_multicycle_o); end
    checks++; if (apu_waddr_o !== '0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", apu_waddr_o); end
  endtask

  task automatic test_issue_delayed_gnt();
    enable_i = 1; apu_lat_i = 2'd0; apu_waddr_i = 6'd5; apu_gnt_i = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      $display("test_issue: wait cycle %0d req=%b stall=%b", c, apu_req_o, apu_stall_o);
      checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL issue_req_wait%0d: got %b expected 1", c, apu_req_o); end
      checks++; if (apu_stall_o !== 1'b1) begin errors++; $display("FAIL issue_stall_wait%0d: got %b expected 1", c, apu_stall_o); end
      checks++; if (perf_cont_o !== 1'b1) begin errors++; $display("FAIL issue_cont_wait%0d: got %b expected 1", c, perf_cont_o); end
      step();
    end
    apu_gnt_i = 1;
    #1;
    $display("test_issue: granted waddr=5");
    checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL issue_req_gnt: got %b expected 1", apu_req_o); end
    checks++; if ({apu_stall_o, perf_cont_o} !== 2'b00) begin errors++; $display("FAIL issue_stall_gnt: got %b expected 00", {apu_stall_o, perf_cont_o}); end
    step();
    enable_i = 0; apu_gnt_i = 0; apu_rvalid_i = 1;
    #1;
    $display("test_issue: result waddr=%0d", apu_waddr_o);
    checks++; if (apu_valid_o !== 1'b1) begin errors++; $display("FAIL issue_valid: got %b expected 1", apu_valid_o); end
    checks++; if (apu_waddr_o !== 6'd5) begin errors++; $display("FAIL issue_waddr: got %0d expected 5", apu_waddr_o); end
    checks++; if ({apu_singlecycle_o, apu_multicycle_o} !== 2'b10) begin errors++; $display("FAIL issue_class: got %b expected 10", {apu_singlecycle_o, apu_multicycle_o}); end
    step();
    apu_rvalid_i = 0;
    #1;
    checks++; if (apu_active_o !== 1'b0) begin errors++; $display("FAIL issue_drained: got %b expected 0", apu_active_o); end
  endtask

  task automatic test_full_queue();
    enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 6'd3; apu_lat_i = 2'd2;
    step();
    apu_waddr_i = 6'd7; apu_lat_i = 2'd1;
    #1;
    checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL full_req_second: got %b expected 1", apu_req_o); end
    step();
    $display("test_full: two ops outstanding, third enable");
    apu_waddr_i = 6'd11; apu_lat_i = 2'd0; apu_rvalid_i = 1;
    #1;
    checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL full_req_blocked: got %b expected 0", apu_req_o); end
    checks++; if ({apu_stall_o, perf_cont_o, perf_type_o} !== 3'b110) begin errors++; $display("FAIL full_perf: got %b expected 110", {apu_stall_o, perf_cont_o, perf_type_o}); end
    checks++; if ({apu_valid_o, apu_waddr_o} !== {1'b1, 6'd3}) begin errors++; $display("FAIL full_pop1: got v=%b w=%0d expected v=1 w=3", apu_valid_o, apu_waddr_o); end
    checks++; if ({apu_singlecycle_o, apu_multicycle_o} !== 2'b01) begin errors++; $display("FAIL full_pop1_class: got %b expected 01", {apu_singlecycle_o, apu_multicycle_o}); end
    step();
    apu_rvalid_i = 0; apu_gnt_i = 0;
    #1;
    checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL full_req_freed: got %b expected 1", apu_req_o); end
    enable_i = 0;
    step();
    apu_rvalid_i = 1;
    #1;
    $display("test_full: second result waddr=%0d", apu_waddr_o);
    checks++; if ({apu_valid_o, apu_waddr_o} !== {1'b1, 6'd7}) begin errors++; $display("FAIL full_pop2: got v=%b w=%0d expected v=1 w=7", apu_valid_o, apu_waddr_o); end
    checks++; if ({apu_singlecycle_o, apu_multicycle_o} !== 2'b00) begin errors++; $display("FAIL full_pop2_class: got %b expected 00", {apu_singlecycle_o, apu_multicycle_o}); end
    step();
    apu_rvalid_i = 0;
    #1;
    checks++; if (apu_active_o !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", apu_active_o); end
  endtask

  task automatic test_hazard();
    enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 6'd9; apu_lat_i = 2'd1;
    step();
    enable_i = 0; apu_gnt_i = 0;
    is_decoding_i = 1;
    read_regs_i = {6'd0, 6'd9, 6'd0}; read_regs_valid_i = 3'b010;
    enable_i = 1; apu_waddr_i = 6'd4;
    #1;
    $display("test_hazard: RAW on r9");
    checks++; if (read_dep_o !== 1'b1) begin errors++; $display("FAIL haz_raw: got %b expected 1", read_dep_o); end
    checks++; if ({perf_type_o, perf_cont_o, apu_req_o, apu_stall_o} !== 4'b1001) begin errors++;
      $display("FAIL haz_raw_ctrl: got %b expected 1001", {perf_type_o, perf_cont_o, apu_req_o, apu_stall_o}); end
    read_regs_valid_i = 3'b000;
    #1;
    checks++; if ({read_dep_o, apu_req_o} !== 2'b01) begin errors++; $display("FAIL haz_raw_invalid: got %b expected 01", {read_dep_o, apu_req_o}); end
    read_regs_i = {6'd8, 6'd8, 6'd8}; read_regs_valid_i = 3'b111;
    #1;
    checks++; if (read_dep_o !== 1'b0) begin errors++; $display("FAIL haz_raw_miss: got %b expected 0", read_dep_o); end
    read_regs_valid_i = 3'b000; enable_i = 0;
    write_regs_i = {6'd1, 6'd9}; write_regs_valid_i = 2'b01;
    #1;
    $display("test_hazard: WAW on r9");
    checks++; if (write_dep_o !== 1'b1) begin errors++; $display("FAIL haz_waw: got %b expected 1", write_dep_o); end
    is_decoding_i = 0;
    #1;
    checks++; if (write_dep_o !== 1'b0) begin errors++; $display("FAIL haz_waw_nodecode: got %b expected 0", write_dep_o); end
    is_decoding_i = 1; apu_rvalid_i = 1;
    #1;
    checks++; if ({apu_valid_o, write_dep_o} !== 2'b11) begin errors++; $display("FAIL haz_pop_conservative: got %b expected 11", {apu_valid_o, write_dep_o}); end
    step();
    idle_inputs();
    #1;
    checks++; if (apu_active_o !== 1'b0) begin errors++; $display("FAIL haz_drained: got %b expected 0", apu_active_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] lat_tbl [0:6];
    lat_tbl[0] = 2'd0; lat_tbl[1] = 2'd1; lat_tbl[2] = 2'd2; lat_tbl[3] = 2'd3;
    lat_tbl[4] = 2'd0; lat_tbl[5] = 2'd2; lat_tbl[6] = 2'd1;
    enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 6'd20; apu_lat_i = lat_tbl[0];
    step();
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] plat;
      plat = lat_tbl[k-1];
      apu_waddr_i = 6'(20 + k); apu_lat_i = lat_tbl[k]; apu_rvalid_i = 1;
      #1;
      $display("test_b2b: push waddr=%0d pop waddr=%0d", 20 + k, apu_waddr_o);
      checks++; if ({apu_req_o, apu_valid_o, apu_stall_o} !== 3'b110) begin errors++;
        $display("FAIL b2b_hs%0d: got %b expected 110", k, {apu_req_o, apu_valid_o, apu_stall_o}); end
      checks++; if (apu_waddr_o !== 6'(19 + k)) begin errors++; $display("FAIL b2b_order%0d: got %0d expected %0d", k, apu_waddr_o, 19 + k); end
      checks++; if ({apu_singlecycle_o, apu_multicycle_o} !== {plat == 2'd0, plat >= 2'd2}) begin errors++;
        $display("FAIL b2b_class%0d: got %b expected %b", k, {apu_singlecycle_o, apu_multicycle_o}, {plat == 2'd0, plat >= 2'd2}); end
      step();
    end
    idle_inputs();
    #1;
    checks++; if (apu_active_o !== 1'b1) begin errors++; $display("FAIL b2b_count: got %b expected 1", apu_active_o); end
    apu_rvalid_i = 1;
    #1;
    checks++; if ({apu_valid_o, apu_waddr_o} !== {1'b1, 6'd26}) begin errors++; $display("FAIL b2b_last: got v=%b w=%0d expected v=1 w=26", apu_valid_o, apu_waddr_o); end
    step();
    apu_rvalid_i = 0;
    #1;
    checks++; if (apu_active_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", apu_active_o); end
  endtask

  task automatic test_reset_midop();
    enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 6'd1; apu_lat_i = 2'd2;
    step();
    apu_waddr_i = 6'd2;
    step();
    idle_inputs();
    #1;
    checks++; if (apu_active_o !== 1'b1) begin errors++; $display("FAIL rst_pre_active: got %b expected 1", apu_active_o); end
    rst_n = 0;
    #1;
    $display("test_reset_midop: reset with two ops outstanding");
    checks++; if ({apu_active_o, apu_waddr_o} !== {1'b0, 6'd0}) begin errors++; $display("FAIL rst_async: got a=%b w=%0d expected a=0 w=0", apu_active_o, apu_waddr_o); end
    step();
    rst_n = 1;
    step();
    apu_rvalid_i = 1;
    #1;
    checks++; if ({apu_valid_o, apu_active_o} !== 2'b00) begin errors++; $display("FAIL rst_late_rvalid: got %b expected 00", {apu_valid_o, apu_active_o}); end
    step();
    apu_rvalid_i = 0;
  endtask

  initial begin
    test_reset();
    test_issue_delayed_gnt();
    test_full_queue();
    test_hazard();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
